// File: rtl/riscv_execute_muldiv_pkg.sv
// riscv_execute_muldiv_pkg
// Shared constants for the iterative RV32M multiply/divide unit:
//   RV_XLEN        default operand/result width
//   F3_*           RV32M funct3 encodings
//   muldiv_state_t FSM state encoding
//   f3_a_signed / f3_b_signed  operand signedness per funct3
package riscv_execute_muldiv_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  // rs1 is signed for everything except the fully unsigned ops
  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// riscv_muldiv_step
// One combinational iteration of the multiply/divide datapath.
// Accumulator layout is {hi, lo}, each XLEN bits.
//   multiply: hi = partial sum, lo = remaining multiplier bits; add-and-shift right
//   divide:   hi = partial remainder, lo = dividend bits shifting out / quotient in
// Ports:
//   i_acc    current accumulator
//   i_op     multiplicand (multiply) or divisor magnitude (divide)
//   i_is_div selects the restoring-divide step
//   o_acc    next accumulator (divide: quotient LSB left at 0)
//   o_qbit   quotient bit for this step (0 for multiply)
module riscv_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_op,
  input  logic              i_is_div,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  assign w_hi    = i_acc[2*XLEN-1:XLEN];
  assign w_lo    = i_acc[XLEN-1:0];
  assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_op} : '0);
  assign w_shift = {w_hi, w_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_op};

  // Trial subtract succeeds when no borrow; the shifted remainder is < 2*divisor,
  // so a successful difference always fits in XLEN bits.
  always_comb begin
    o_acc  = '0;
    o_qbit = 1'b0;
    if (i_is_div) begin
      o_qbit = ~w_diff[XLEN];
      o_acc  = {(o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), w_lo[XLEN-2:0], 1'b0};
    end else begin
      o_acc  = {w_sum, w_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_execute_muldiv.sv
// riscv_execute_muldiv
// Iterative RV32M multiply/divide unit in the execute stage. One step per cycle
// on operand magnitudes, sign/special-case fixup in FIX, one-cycle done pulse.
// Optional feature macro: RISCV_MULDIV_EARLY_OUT_EN (divide-by-zero and signed
// overflow go straight from IDLE to DONE with the result registered at accept).
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_muldiv_valid/funct3/rs1/rs2/rd  request from ID/EX
//   i_muldiv_kill                flush: abort in-flight op / block accept
//   o_muldiv_ready               unit idle
//   o_muldiv_busy                stall request
//   o_muldiv_done                one-cycle result pulse
//   o_muldiv_result, o_muldiv_rd result and destination tag
module riscv_execute_muldiv
  import riscv_execute_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = RV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_muldiv_valid,
  input  logic [2:0]      i_muldiv_funct3,
  input  logic [XLEN-1:0] i_muldiv_rs1,
  input  logic [XLEN-1:0] i_muldiv_rs2,
  input  logic [4:0]      i_muldiv_rd,
  input  logic            i_muldiv_kill,
  output logic            o_muldiv_ready,
  output logic            o_muldiv_busy,
  output logic            o_muldiv_done,
  output logic [XLEN-1:0] o_muldiv_result,
  output logic [4:0]      o_muldiv_rd
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  muldiv_state_t    r_state;
  muldiv_state_t    w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [XLEN-1:0]  r_op;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic             r_a_neg;
  logic             r_b_neg;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_in_div;
  logic             w_in_a_neg;
  logic             w_in_b_neg;
  logic             w_in_div_zero;
  logic [XLEN-1:0]  w_in_a_mag;
  logic [XLEN-1:0]  w_in_b_mag;
  logic             w_early;
  logic [XLEN-1:0]  w_early_result;
  logic [ACC_W-1:0] w_acc_step;
  logic             w_qbit;
  logic [ACC_W-1:0] w_prod;
  logic [XLEN-1:0]  w_quot;
  logic [XLEN-1:0]  w_rem;
  logic [XLEN-1:0]  w_fix_result;

  // Accept-time operand decode
  assign w_accept      = (r_state == ST_IDLE) & i_muldiv_valid & ~i_muldiv_kill;
  assign w_in_div      = i_muldiv_funct3[2];
  assign w_in_a_neg    = f3_a_signed(i_muldiv_funct3) & i_muldiv_rs1[XLEN-1];
  assign w_in_b_neg    = f3_b_signed(i_muldiv_funct3) & i_muldiv_rs2[XLEN-1];
  assign w_in_a_mag    = w_in_a_neg ? -i_muldiv_rs1 : i_muldiv_rs1;
  assign w_in_b_mag    = w_in_b_neg ? -i_muldiv_rs2 : i_muldiv_rs2;
  assign w_in_div_zero = w_in_div & (i_muldiv_rs2 == '0);

`ifdef RISCV_MULDIV_EARLY_OUT_EN
  logic w_in_div_ovf;
  assign w_in_div_ovf = w_in_div & f3_b_signed(i_muldiv_funct3)
                      & (i_muldiv_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                      & (i_muldiv_rs2 == '1);
  assign w_early      = w_in_div_zero | w_in_div_ovf;
  // x/0: q=all ones, r=rs1. MIN/-1: q=rs1 (MIN), r=0.
  assign w_early_result = i_muldiv_funct3[1] ? (w_in_div_zero ? i_muldiv_rs1 : '0)
                                             : (w_in_div_zero ? '1 : i_muldiv_rs1);
`else
  assign w_early        = 1'b0;
  assign w_early_result = '0;
`endif

  riscv_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc    (r_acc),
    .i_op     (r_op),
    .i_is_div (r_funct3[2]),
    .o_acc    (w_acc_step),
    .o_qbit   (w_qbit)
  );

  // Sign fixup. Divide by zero yields remainder = |rs1| and all-ones quotient from
  // the iteration itself, so only the quotient sign flip must be overridden.
  // Signed overflow already comes out as MIN quotient and zero remainder.
  assign w_prod = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
  assign w_quot = r_acc[XLEN-1:0];
  assign w_rem  = r_acc[ACC_W-1:XLEN];

  always_comb begin
    w_fix_result = '0;
    if (!r_funct3[2]) begin
      w_fix_result = (r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[ACC_W-1:XLEN];
    end else if (r_funct3[1]) begin
      w_fix_result = r_a_neg ? -w_rem : w_rem;
    end else if (r_div_zero) begin
      w_fix_result = '1;
    end else begin
      w_fix_result = (r_a_neg ^ r_b_neg) ? -w_quot : w_quot;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_early ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (i_muldiv_kill)      w_state_next = ST_IDLE;
        else if (r_cnt == '0)   w_state_next = ST_FIX;
      end
      ST_FIX:  w_state_next = i_muldiv_kill ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status flags registered from the next state so they mirror the state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_muldiv_ready <= 1'b1;
      o_muldiv_busy  <= 1'b0;
      o_muldiv_done  <= 1'b0;
    end else begin
      o_muldiv_ready <= (w_state_next == ST_IDLE);
      o_muldiv_busy  <= (w_state_next != ST_IDLE);
      o_muldiv_done  <= (w_state_next == ST_DONE);
    end
  end

  // Datapath and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt           <= '0;
      r_acc           <= '0;
      r_op            <= '0;
      r_funct3        <= '0;
      r_rd            <= '0;
      r_a_neg         <= 1'b0;
      r_b_neg         <= 1'b0;
      r_div_zero      <= 1'b0;
      o_muldiv_result <= '0;
      o_muldiv_rd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt      <= CNT_W'(XLEN - 1);
            r_funct3   <= i_muldiv_funct3;
            r_rd       <= i_muldiv_rd;
            r_a_neg    <= w_in_a_neg;
            r_b_neg    <= w_in_b_neg;
            r_div_zero <= w_in_div_zero;
            // divide: lo = dividend, op = divisor; multiply: lo = multiplier (rs2)
            r_op       <= w_in_div ? w_in_b_mag : w_in_a_mag;
            r_acc      <= {{XLEN{1'b0}}, (w_in_div ? w_in_a_mag : w_in_b_mag)};
            if (w_early) begin
              o_muldiv_result <= w_early_result;
              o_muldiv_rd     <= i_muldiv_rd;
            end
          end
        end
        ST_CALC: begin
          if (!i_muldiv_kill) begin
            r_acc <= w_acc_step | ACC_W'(w_qbit);
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!i_muldiv_kill) begin
            o_muldiv_result <= w_fix_result;
            o_muldiv_rd     <= r_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_execute_muldiv.sv
// tb_riscv_execute_muldiv
// Directed vectors with a scoreboard queue; a monitor pops on every done pulse.
module tb_riscv_execute_muldiv;
  import riscv_execute_muldiv_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd;
  logic            kill;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  riscv_execute_muldiv #(.XLEN(XLEN)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_muldiv_valid  (valid),
    .i_muldiv_funct3 (funct3),
    .i_muldiv_rs1    (rs1),
    .i_muldiv_rs2    (rs2),
    .i_muldiv_rd     (rd),
    .i_muldiv_kill   (kill),
    .o_muldiv_ready  (ready),
    .o_muldiv_busy   (busy),
    .o_muldiv_done   (done),
    .o_muldiv_result (result),
    .o_muldiv_rd     (rd_out)
  );

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done result=%h rd=%0d", result, rd_out);
      end else begin
        e = sb_q.pop_front();
        if (result !== e.res || rd_out !== e.rd) begin
          errors++;
          $display("FAIL scoreboard got result=%h rd=%0d expected result=%h rd=%0d",
                   result, rd_out, e.res, e.rd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Present one request and return right after its accepting edge
  task automatic send(input logic [2:0] f, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [4:0] t);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    funct3 = f; rs1 = a; rs2 = b; rd = t; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Count cycles from accept to done; busy/ready must show a stalled unit meanwhile
  task automatic wait_done(input string name, input int lat, input logic [XLEN-1:0] exp);
    int cyc = 0;
    logic stall_ok = 1'b1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (!busy || ready) stall_ok = 1'b0;
    end
    check({name, "_latency"}, 64'(cyc), 64'(lat));
    check({name, "_busy"}, 64'(stall_ok), 64'd1);
    @(negedge clk);
    check({name, "_after_done"}, {31'd0, done, 31'd0, ready, result},
          {31'd0, 1'b0, 31'd0, 1'b1, exp});
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] t,
                       input logic [XLEN-1:0] exp, input int lat);
    send(f, a, b, t);
    sb_q.push_back('{res: exp, rd: t});
    wait_done(name, lat, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_state", {ready, busy, done, rd_out, result}, {1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("mulh_min",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
    do_op("mulhsu_m1",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 34);
    do_op("mul_m1",     F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 34);
    do_op("mulhu_m1",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 34);
    do_op("div_m7_2",   F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2",   F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 34);
    do_op("divu_100_7", F3_DIVU,   32'd100,       32'd7,         5'd7, 32'd14,        34);
    do_op("divu_zero",  F3_DIVU,   32'h0000_1234, 32'd0,         5'd8, 32'hFFFF_FFFF, SPECIAL_LAT);
    do_op("remu_zero",  F3_REMU,   32'h0000_1234, 32'd0,         5'd9, 32'h0000_1234, SPECIAL_LAT);
    do_op("div_m7_0",   F3_DIV,    32'hFFFF_FFF9, 32'd0,         5'd10, 32'hFFFF_FFFF, SPECIAL_LAT);
    do_op("rem_m7_0",   F3_REM,    32'hFFFF_FFF9, 32'd0,         5'd11, 32'hFFFF_FFF9, SPECIAL_LAT);
    do_op("div_ovf",    F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, SPECIAL_LAT);
    do_op("rem_ovf",    F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, SPECIAL_LAT);
    do_op("remu_100_7", F3_REMU,   32'd100,       32'd7,         5'd14, 32'd2,         34);

    // Valid with kill in IDLE must not be accepted
    @(negedge clk);
    funct3 = F3_MUL; rs1 = 32'd9; rs2 = 32'd9; rd = 5'd20; valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    valid = 1'b0; kill = 1'b0;
    check("kill_idle_no_accept", {ready, busy}, {1'b1, 1'b0});

    // Kill at CALC cycle 10: no done, IDLE next cycle, previous result held
    send(F3_MUL, 32'd6, 32'd7, 5'd21);
    repeat (10) @(negedge clk);
    check("calc_before_kill", {ready, busy}, {1'b0, 1'b1});
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_to_idle", {ready, busy, done}, {1'b1, 1'b0, 1'b0});
    check("kill_holds_result", {rd_out, result}, {5'd14, 32'd2});
    do_op("mul_after_kill", F3_MUL, 32'd6, 32'd7, 5'd22, 32'd42, 34);

    // Asynchronous reset mid-CALC
    send(F3_MUL, 32'h1234, 32'h10, 5'd23);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {ready, busy, done, rd_out, result}, {1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    do_op("mul_3_5", F3_MUL, 32'd3, 32'd5, 5'd24, 32'd15, 34);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
